// File: rtl/time_display_io.sv
// rtl/time_display_io.sv - tear-free HH:MM:SS 7-segment driver with alarm blink and key debounce
module time_display_io #(
    parameter int SAMPLE_CYCLES     = 50_000,
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int BLINK_HALF_CYCLES = 12_500_000
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic [15:0] hours_export,
    input  logic [15:0] minutes_export,
    input  logic [15:0] seconds_export,
    input  logic        alarm_export,
    input  logic [3:0]  key_n,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic [3:0]  btn_level,
    output logic [3:0]  btn_pulse,
    output logic        alarm_led
);

    localparam int SW = $clog2(SAMPLE_CYCLES + 1);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int BW = $clog2(BLINK_HALF_CYCLES + 1);
    localparam logic [6:0] DASH = 7'b0111111;

    logic [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic [23:0]   samp_q, samp_d, disp_q, disp_d;
    logic          samp_vld_q, samp_vld_d, committed_q, committed_d;
    logic [41:0]   hex_q, hex_d;
    logic [1:0]    alarm_sync_q, alarm_sync_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          phase_q, phase_d;
    logic [3:0]    key_s1_q, key_s1_d, key_s2_q, key_s2_d;
    logic [3:0]    btn_level_q, btn_level_d, btn_pulse_q, btn_pulse_d;
    logic [DW-1:0] deb_cnt_q [4];
    logic [DW-1:0] deb_cnt_d [4];
    logic [3:0]    pressed;
    logic [23:0]   cur;
    logic          unused_hi;

    assign cur       = {hours_export[7:0], minutes_export[7:0], seconds_export[7:0]};
    assign unused_hi = ^{hours_export[15:8], minutes_export[15:8], seconds_export[15:8]};

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    function automatic logic [13:0] decode_field(input logic [7:0] v, input logic [7:0] lim);
        logic [3:0] tens;
        logic [3:0] ones;
        tens = 4'(v / 8'd10);
        ones = 4'(v % 8'd10);
        if (v < lim) decode_field = {seg7(tens), seg7(ones)};
        else         decode_field = {DASH, DASH};
    endfunction

    always_comb begin
        samp_cnt_d  = samp_cnt_q + 1'b1;
        samp_d      = samp_q;
        samp_vld_d  = samp_vld_q;
        disp_d      = disp_q;
        committed_d = committed_q;
        // A snapshot is only shown once two consecutive ticks agree, so a half-written time never appears.
        if (samp_cnt_q == SW'(SAMPLE_CYCLES - 1)) begin
            samp_cnt_d = '0;
            samp_d     = cur;
            samp_vld_d = 1'b1;
            if (samp_vld_q && cur == samp_q) begin
                disp_d      = cur;
                committed_d = 1'b1;
            end
        end

        if (committed_q)
            hex_d = {decode_field(disp_q[23:16], 8'd24),
                     decode_field(disp_q[15:8], 8'd60),
                     decode_field(disp_q[7:0], 8'd60)};
        else
            hex_d = '1;

        alarm_sync_d = {alarm_sync_q[0], alarm_export};
        blink_cnt_d  = blink_cnt_q + 1'b1;
        phase_d      = phase_q;
        if (!alarm_sync_q[1]) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_cnt_q == BW'(BLINK_HALF_CYCLES - 1)) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end

        key_s1_d    = key_n;
        key_s2_d    = key_s1_q;
        pressed     = ~key_s2_q;
        btn_level_d = btn_level_q;
        for (int i = 0; i < 4; i++) begin
            deb_cnt_d[i] = '0;
            if (pressed[i] != btn_level_q[i]) begin
                if (deb_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1))
                    btn_level_d[i] = pressed[i];
                else
                    deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
            end
        end
        btn_pulse_d = btn_level_d & ~btn_level_q;
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            samp_cnt_q   <= '0;
            samp_q       <= '0;
            samp_vld_q   <= 1'b0;
            disp_q       <= '0;
            committed_q  <= 1'b0;
            hex_q        <= '1;
            alarm_sync_q <= '0;
            blink_cnt_q  <= '0;
            phase_q      <= 1'b1;
            key_s1_q     <= '1;
            key_s2_q     <= '1;
            btn_level_q  <= '0;
            btn_pulse_q  <= '0;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
        end else begin
            samp_cnt_q   <= samp_cnt_d;
            samp_q       <= samp_d;
            samp_vld_q   <= samp_vld_d;
            disp_q       <= disp_d;
            committed_q  <= committed_d;
            hex_q        <= hex_d;
            alarm_sync_q <= alarm_sync_d;
            blink_cnt_q  <= blink_cnt_d;
            phase_q      <= phase_d;
            key_s1_q     <= key_s1_d;
            key_s2_q     <= key_s2_d;
            btn_level_q  <= btn_level_d;
            btn_pulse_q  <= btn_pulse_d;
            for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
        end
    end

    assign {hex5, hex4, hex3, hex2, hex1, hex0} = phase_q ? hex_q : {42{1'b1}};
    assign alarm_led = alarm_sync_q[1] & phase_q;
    assign btn_level = btn_level_q;
    assign btn_pulse = btn_pulse_q;

endmodule

// File: tb/tb_time_display_io.sv
// tb/tb_time_display_io.sv - scoreboard bench for time_display_io, checks each output change and its cycle
module tb_time_display_io;

    logic        clk;
    logic        rst_n;
    logic [15:0] h, m, s;
    logic        alarm;
    logic [3:0]  key_n;
    logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
    logic [3:0]  btn_level, btn_pulse;
    logic        alarm_led;

    time_display_io #(
        .SAMPLE_CYCLES(4), .DEBOUNCE_CYCLES(8), .BLINK_HALF_CYCLES(16)
    ) dut (
        .clk_clk(clk), .reset_reset_n(rst_n),
        .hours_export(h), .minutes_export(m), .seconds_export(s),
        .alarm_export(alarm), .key_n(key_n),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .btn_level(btn_level), .btn_pulse(btn_pulse), .alarm_led(alarm_led)
    );

    localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100, S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001, S5 = 7'b0010010, S6 = 7'b0000010, S7 = 7'b1111000;
    localparam logic [6:0] S9 = 7'b0010000, DASH = 7'b0111111;
    localparam logic [41:0] BLANK = {42{1'b1}};
    localparam logic [41:0] LIT_A = {S1, S2, S3, S4, S5, S6};
    localparam logic [41:0] LIT_B = {S1, S2, S5, S9, S5, S6};
    localparam logic [41:0] LIT_C = {DASH, DASH, S0, S7, S0, S0};

    typedef struct {
        logic [50:0] vec;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [41:0] e_hex;
    logic [3:0]  e_lvl, e_pls;
    logic        e_led;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push(input int c);
        exp_t e;
        e.vec = {e_hex, e_lvl, e_pls, e_led};
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #3;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) step();
    endtask

    task automatic wait_drain(input int n, input string name);
        for (int i = 0; i < n && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d expected changes still pending, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: every change of the output bundle must match the next queued expectation.
    initial begin
        logic [50:0] prev;
        logic [50:0] now;
        exp_t        e;
        prev = 'x;
        forever begin
            @(negedge clk);
            now = {hex5, hex4, hex3, hex2, hex1, hex0, btn_level, btn_pulse, alarm_led};
            if (now !== prev) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change: got %h at cycle %0d, required no change", now, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (now !== e.vec) begin
                        errors++;
                        $display("FAIL outputs: got %h, required %h (cycle %0d)", now, e.vec, cyc);
                    end
                    if (e.cyc >= 0) begin
                        checks++;
                        if (cyc != e.cyc) begin
                            errors++;
                            $display("FAIL change_cycle: got %0d, required %0d", cyc, e.cyc);
                        end
                    end
                end
                prev = now;
            end
        end
    end

    initial begin
        int c0, c2, c3;
        rst_n = 1'b0;
        h = 16'd12; m = 16'd34; s = 16'd56;
        alarm = 1'b0;
        key_n = 4'hF;
        e_hex = BLANK; e_lvl = 4'h0; e_pls = 4'h0; e_led = 1'b0;
        push(-1);
        repeat (3) step();
        wait_drain(5, "reset");

        step(); rst_n = 1'b1; c0 = cyc;
        e_hex = LIT_A; push(c0 + 9);
        wait_drain(20, "commit");

        for (int i = 0; i < 40; i++) begin
            step(); m = 16'(i);
        end
        step(); m = 16'd59;
        e_hex = LIT_B; push(-1);
        wait_drain(30, "settle");

        step(); h = 16'd24; m = 16'd7; s = 16'd0;
        e_hex = LIT_C; push(-1);
        wait_drain(30, "invalid");

        step(); alarm = 1'b1; c0 = cyc;
        e_led = 1'b1; push(c0 + 2);
        e_hex = BLANK; e_led = 1'b0; push(c0 + 18);
        e_hex = LIT_C; e_led = 1'b1; push(c0 + 34);
        e_hex = BLANK; e_led = 1'b0; push(c0 + 50);
        wait_until(c0 + 52); alarm = 1'b0;
        e_hex = LIT_C; push(c0 + 55);
        wait_drain(10, "blink");

        step(); key_n[2] = 1'b0;
        repeat (5) step();
        key_n[2] = 1'b1;
        repeat (12) step();
        key_n[2] = 1'b0; c2 = cyc;
        e_lvl = 4'h4; e_pls = 4'h4; push(c2 + 10);
        e_pls = 4'h0; push(c2 + 11);
        wait_until(c2 + 20); key_n[2] = 1'b1;
        e_lvl = 4'h0; push(c2 + 30);
        wait_drain(20, "debounce");

        step(); alarm = 1'b1; key_n[2] = 1'b0; c0 = cyc;
        e_led = 1'b1; push(c0 + 2);
        e_lvl = 4'h4; e_pls = 4'h4; push(c0 + 10);
        e_pls = 4'h0; push(c0 + 11);
        e_hex = BLANK; e_led = 1'b0; push(c0 + 18);
        e_lvl = 4'h0; push(c0 + 25);
        wait_until(c0 + 25); rst_n = 1'b0;
        wait_until(c0 + 27); rst_n = 1'b1; c3 = cyc;
        e_led = 1'b1; push(c3 + 2);
        e_hex = LIT_C; push(c3 + 9);
        e_lvl = 4'h4; e_pls = 4'h4; push(c3 + 10);
        e_pls = 4'h0; push(c3 + 11);
        e_hex = BLANK; e_led = 1'b0; push(c3 + 18);
        wait_drain(30, "reset_mid");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
